// File: rtl/bandscope_capture.sv
// Bandscope capture sequencer: a ms-scale period timer triggers DEPTH-sample
// frame captures into an external RAM. Each finished frame is handed to a slow
// reader through a toggle handshake, and the frame is held until the reader
// acknowledges it.
//
//   state | meaning
//   IDLE  | disabled; timer held at zero
//   WAIT  | armed, waiting for the next period expiry
//   FILL  | writing strobed samples into the frame RAM
//   HOLD  | frame complete, waiting for bs_ack from the reader
//   DONE  | single-shot finished; needs bs_on low then high to re-arm
module bandscope_capture #(
  parameter int ADDR_W         = 12,
  parameter int PERIOD_W       = 8,
  parameter int DECIM_W        = 4,
  parameter int TICK_DIV       = 600,
  parameter int TICKS_PER_UNIT = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                bs_on,
  input  logic                bs_single,
  input  logic [PERIOD_W-1:0] bs_period,
  input  logic [DECIM_W-1:0]  bs_decim,
  input  logic                sample_stb,
  input  logic                bs_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                bs_ready,
  output logic                bs_busy,
  output logic                bs_overrun,
  output logic [7:0]          frame_cnt
);

  localparam int CW  = PERIOD_W + 8;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FILL, S_HOLD, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [PSW-1:0]      r_presc;
  logic [CW-1:0]       r_pcnt;
  logic [CW-1:0]       w_comp;
  logic                w_run, w_tick, w_expiry;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_slot;     // writes requested this frame; MSB set = frame full
  logic [DECIM_W-1:0]  r_dcnt;
  logic                r_we, r_ready, r_pending, r_overrun;
  logic [7:0]          r_fcnt;
  logic                w_fill, w_wr_req, w_frame_done, w_enter_fill;

  assign w_comp   = CW'(bs_period) * CW'(TICKS_PER_UNIT);
  assign w_run    = (r_state != S_IDLE) && bs_on;
  assign w_tick   = w_run && (r_presc == PSW'(TICK_DIV - 1));
  assign w_expiry = w_tick && (r_pcnt == w_comp);

  assign w_fill       = (r_state == S_FILL);
  assign w_wr_req     = w_fill && sample_stb && (r_dcnt == '0) && !r_slot[ADDR_W];
  // Frame ends on the cycle the last slot is actually written, so the reader
  // never sees bs_ready before the final sample lands in RAM.
  assign w_frame_done = w_fill && r_we && (r_addr == '1);
  assign w_enter_fill = (w_next == S_FILL) && (r_state != S_FILL);

  // Prescaler and period counter; both held at zero whenever the sequencer is idle
  always_ff @(posedge clock) begin
    if (!reset_n || !w_run) begin
      r_presc <= '0;
      r_pcnt  <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_pcnt  <= w_expiry ? '0 : r_pcnt + CW'(1);
    end else begin
      r_presc <= r_presc + PSW'(1);
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; dropping bs_on overrides everything
  always_comb begin
    w_next = r_state;
    if (!bs_on) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_WAIT;
        S_WAIT: if (w_expiry) w_next = S_FILL;
        S_FILL: if (w_frame_done) w_next = S_HOLD;
        S_HOLD: begin
          if (bs_ack) begin
            if (bs_single)                   w_next = S_DONE;
            else if (r_pending || w_expiry)  w_next = S_FILL;
            else                             w_next = S_WAIT;
          end
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Frame write datapath, reader handshake, pending/overrun bookkeeping
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_slot    <= '0;
      r_dcnt    <= '0;
      r_ready   <= 1'b0;
      r_fcnt    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!bs_on) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_slot    <= '0;
      r_dcnt    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_we <= w_wr_req;
      if (w_enter_fill) begin
        r_addr <= '0;
        r_slot <= '0;
        r_dcnt <= '0;
      end else begin
        if (r_we)     r_addr <= r_addr + ADDR_W'(1);
        if (w_wr_req) r_slot <= r_slot + (ADDR_W+1)'(1);
        if (w_fill && sample_stb)
          r_dcnt <= (r_dcnt >= bs_decim) ? '0 : r_dcnt + DECIM_W'(1);
      end
      if (w_frame_done) begin
        r_ready <= ~r_ready;
        r_fcnt  <= r_fcnt + 8'd1;
      end
      case (r_state)
        S_FILL: begin
          if (w_expiry) begin
            if (r_pending) r_overrun <= 1'b1;
            r_pending <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_expiry && r_pending) r_overrun <= 1'b1;
          // An expiry coinciding with the ack is consumed by the FILL restart
          if (bs_ack)        r_pending <= 1'b0;
          else if (w_expiry) r_pending <= 1'b1;
        end
        default: r_pending <= 1'b0;
      endcase
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign bs_ready   = r_ready;
  assign bs_busy    = (r_state == S_FILL) || (r_state == S_HOLD);
  assign bs_overrun = r_overrun;
  assign frame_cnt  = r_fcnt;

endmodule
